// File: rtl/cpu_axi_bridge_if.sv
// CPU SRAM-like instruction/data ports plus one AXI3 master port, bundled for cpu_axi_bridge.
// The master modport is the bridge's view; slave is the CPU core plus interconnect side.
interface cpu_axi_bridge_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Converts CPU SRAM-like inst/data requests into single-beat AXI3 transactions.
// At most one read, one write, and one transaction per data port in flight, so order is kept.
module cpu_axi_bridge (
    input  logic             clk,
    input  logic             reset,
    cpu_axi_bridge_if.master bus
);

    typedef enum logic [1:0] {RIdle, RAr, RR} r_state_e;
    typedef enum logic [1:0] {WIdle, WAw, WB} w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        data_busy_q, data_busy_d;

    logic [31:0] r_addr_q;
    logic [1:0]  r_size_q;
    logic        r_id_q;
    logic [31:0] w_addr_q;
    logic [1:0]  w_size_q;
    logic [3:0]  w_strb_q;
    logic [31:0] w_data_q;

    logic        data_rd_acc, data_wr_acc, inst_rd_acc;
    logic        aw_hs, w_hs;
    logic        rd_done, inst_done, data_rd_done, wr_done;

    always_comb begin
        data_rd_acc = ~reset & bus.data_req & ~bus.data_wr & (r_state_q == RIdle)
                      & ~data_busy_q & (w_state_q == WIdle);
        data_wr_acc = ~reset & bus.data_req & bus.data_wr & (w_state_q == WIdle) & ~data_busy_q;
        inst_rd_acc = ~reset & bus.inst_req & (r_state_q == RIdle) & ~data_rd_acc;
    end

    assign aw_hs        = bus.awvalid & bus.awready;
    assign w_hs         = bus.wvalid & bus.wready;
    assign rd_done      = ~reset & bus.rvalid & bus.rready;
    assign inst_done    = rd_done & (bus.rid == 4'd0);
    assign data_rd_done = rd_done & (bus.rid == 4'd1);
    assign wr_done      = ~reset & bus.bvalid & bus.bready;

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle:   if (data_rd_acc | inst_rd_acc) r_state_d = RAr;
            RAr:     if (bus.arready) r_state_d = RR;
            RR:      if (bus.rvalid) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    // aw and w channels handshake independently; leave WAw once both have completed.
    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (w_state_q)
            WIdle: begin
                if (data_wr_acc) begin
                    w_state_d = WAw;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WAw: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d & w_done_d) w_state_d = WB;
            end
            WB:      if (bus.bvalid) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        data_busy_d = data_busy_q;
        if (data_rd_acc | data_wr_acc) data_busy_d = 1'b1;
        else if (bus.data_data_ok)     data_busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= RIdle;
            w_state_q   <= WIdle;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            data_busy_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            data_busy_q <= data_busy_d;
        end
    end

    // Payload registers: AXI fields are driven only from these.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_q <= '0;
            r_size_q <= '0;
            r_id_q   <= 1'b0;
            w_addr_q <= '0;
            w_size_q <= '0;
            w_strb_q <= '0;
            w_data_q <= '0;
        end else begin
            if (data_rd_acc) begin
                r_addr_q <= bus.data_addr;
                r_size_q <= bus.data_size;
                r_id_q   <= 1'b1;
            end else if (inst_rd_acc) begin
                r_addr_q <= bus.inst_addr;
                r_size_q <= bus.inst_size;
                r_id_q   <= 1'b0;
            end
            if (data_wr_acc) begin
                w_addr_q <= bus.data_addr;
                w_size_q <= bus.data_size;
                w_strb_q <= bus.data_wstrb;
                w_data_q <= bus.data_wdata;
            end
        end
    end

    assign bus.inst_addr_ok = inst_rd_acc;
    assign bus.data_addr_ok = data_rd_acc | data_wr_acc;
    assign bus.inst_data_ok = inst_done;
    assign bus.data_data_ok = data_rd_done | wr_done;
    assign bus.inst_rdata   = bus.rdata;
    assign bus.data_rdata   = bus.rdata;

    assign bus.arid    = {3'b000, r_id_q};
    assign bus.araddr  = r_addr_q;
    assign bus.arlen   = 4'd0;
    assign bus.arsize  = {1'b0, r_size_q};
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = (r_state_q == RAr);
    assign bus.rready  = (r_state_q == RR);

    assign bus.awid    = 4'd1;
    assign bus.awaddr  = w_addr_q;
    assign bus.awlen   = 4'd0;
    assign bus.awsize  = {1'b0, w_size_q};
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;
    assign bus.awvalid = (w_state_q == WAw) & ~aw_done_q;

    assign bus.wid    = 4'd1;
    assign bus.wdata  = w_data_q;
    assign bus.wstrb  = w_strb_q;
    assign bus.wlast  = 1'b1;
    assign bus.wvalid = (w_state_q == WAw) & ~w_done_q;
    assign bus.bready = (w_state_q == WB);

    logic unused_inputs;
    assign unused_inputs = ^{bus.inst_wr, bus.inst_wstrb, bus.inst_wdata, bus.rresp, bus.rlast,
                             bus.bid, bus.bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: the bench plays both the CPU core and the AXI slave.
module tb_cpu_axi_bridge;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] mem200;

    cpu_axi_bridge_if bus ();

    cpu_axi_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Slave side of the memory model for address 0x200: capture on the w handshake.
    task automatic capture_w();
        if (bus.wvalid && bus.wready && bus.awaddr == 32'h200)
            mem200 = merge(mem200, bus.wdata, bus.wstrb);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mem200 = 32'h0;
        reset  = 1'b1;
        bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 0; bus.inst_wstrb = 0;
        bus.inst_addr = 0; bus.inst_wdata = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
        bus.data_addr = 0; bus.data_wdata = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 1; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bid = 1; bus.bresp = 0; bus.bvalid = 0;

        // Reset state, with requests pending
        tick();
        tick();
        bus.inst_req = 1; bus.data_req = 1;
        #1;
        chk("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("rst_awvalid", {31'd0, bus.awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, bus.wvalid}, 32'd0);
        chk("rst_rready", {31'd0, bus.rready}, 32'd0);
        chk("rst_bready", {31'd0, bus.bready}, 32'd0);
        chk("rst_inst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
        chk("rst_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd0);
        chk("const_ar", {bus.arlen, 2'b0, bus.arburst, bus.arlock, bus.arcache, 1'b0, bus.arprot},
            {4'd0, 2'b0, 2'b01, 2'b00, 4'd0, 1'b0, 3'd0});
        chk("const_aw_w", {bus.awid, bus.awlen, bus.awburst, bus.wid, 3'b0, bus.wlast},
            {4'd1, 4'd0, 2'b01, 4'd1, 3'b0, 1'b1});
        bus.inst_req = 0; bus.data_req = 0;
        tick();
        reset = 0;
        tick();

        // Inst read 0x1c000000
        bus.inst_req = 1; bus.inst_addr = 32'h1c00_0000; bus.inst_size = 2;
        #1;
        chk("t1_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
        tick();
        bus.inst_req = 0; bus.arready = 1;
        #1;
        chk("t1_arvalid", {31'd0, bus.arvalid}, 32'd1);
        chk("t1_arid", {28'd0, bus.arid}, 32'd0);
        chk("t1_araddr", bus.araddr, 32'h1c00_0000);
        chk("t1_arsize", {29'd0, bus.arsize}, 32'd2);
        tick();
        bus.arready = 0; bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h0280_0000;
        #1;
        chk("t1_rready", {31'd0, bus.rready}, 32'd1);
        chk("t1_inst_data_ok", {31'd0, bus.inst_data_ok}, 32'd1);
        chk("t1_inst_rdata", bus.inst_rdata, 32'h0280_0000);
        chk("t1_data_data_ok", {31'd0, bus.data_data_ok}, 32'd0);
        tick();
        bus.rvalid = 0;
        #1;
        chk("t1_pulse_end", {30'd0, bus.inst_data_ok, bus.rready}, 32'd0);

        // Data read wins over inst read
        bus.inst_req = 1; bus.inst_addr = 32'h1c00_0004;
        bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h100; bus.data_size = 2;
        #1;
        chk("t2_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
        chk("t2_inst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
        tick();
        bus.data_req = 0; bus.arready = 1;
        #1;
        chk("t2_arid", {28'd0, bus.arid}, 32'd1);
        chk("t2_araddr", bus.araddr, 32'h100);
        chk("t2_inst_wait_ar", {31'd0, bus.inst_addr_ok}, 32'd0);
        tick();
        bus.arready = 0; bus.rvalid = 1; bus.rid = 1; bus.rdata = 32'h1122_3344;
        #1;
        chk("t2_data_data_ok", {31'd0, bus.data_data_ok}, 32'd1);
        chk("t2_data_rdata", bus.data_rdata, 32'h1122_3344);
        chk("t2_inst_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
        chk("t2_inst_wait_r", {31'd0, bus.inst_addr_ok}, 32'd0);
        tick();
        bus.rvalid = 0;
        #1;
        chk("t2_inst_accept", {31'd0, bus.inst_addr_ok}, 32'd1);
        tick();
        bus.inst_req = 0; bus.arready = 1;
        #1;
        chk("t2_inst_araddr", bus.araddr, 32'h1c00_0004);
        chk("t2_inst_arid", {28'd0, bus.arid}, 32'd0);
        tick();
        bus.arready = 0; bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h5566_7788;
        #1;
        chk("t2_inst_done", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd2);
        tick();
        bus.rvalid = 0;

        // Data write with awready delayed, wready immediate
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h200; bus.data_size = 2;
        bus.data_wstrb = 4'b0011; bus.data_wdata = 32'hdead_beef;
        #1;
        chk("t3_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
        tick();
        bus.data_req = 0; bus.data_wdata = 0; bus.data_wstrb = 0; bus.wready = 1;
        #1;
        chk("t3_c1_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        chk("t3_awaddr", bus.awaddr, 32'h200);
        chk("t3_wdata", bus.wdata, 32'hdead_beef);
        chk("t3_wstrb_size", {25'd0, bus.awsize, bus.wstrb}, {25'd0, 3'd2, 4'b0011});
        capture_w();
        tick();
        bus.wready = 0;
        #1;
        chk("t3_c2_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd2);
        tick();
        bus.awready = 1;
        #1;
        chk("t3_c3_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd2);
        chk("t3_c3_awaddr", bus.awaddr, 32'h200);
        tick();
        bus.awready = 0; bus.bvalid = 1;
        #1;
        chk("t3_c4_awvalid", {31'd0, bus.awvalid}, 32'd0);
        chk("t3_bready", {31'd0, bus.bready}, 32'd1);
        chk("t3_data_data_ok", {31'd0, bus.data_data_ok}, 32'd1);
        tick();
        bus.bvalid = 0;
        #1;
        chk("t3_pulse_end", {30'd0, bus.data_data_ok, bus.bready}, 32'd0);

        // Write in flight blocks a data read to the same address
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h200;
        bus.data_wstrb = 4'b1100; bus.data_wdata = 32'hcafe_0000;
        #1;
        chk("t4_wr_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
        tick();
        bus.data_wr = 0; bus.data_wstrb = 0; bus.data_wdata = 0;
        bus.awready = 1; bus.wready = 1;
        #1;
        chk("t4_rd_block_aw", {31'd0, bus.data_addr_ok}, 32'd0);
        capture_w();
        tick();
        bus.awready = 0; bus.wready = 0;
        #1;
        chk("t4_rd_block_b", {31'd0, bus.data_addr_ok}, 32'd0);
        tick();
        bus.bvalid = 1;
        #1;
        chk("t4_wr_done", {31'd0, bus.data_data_ok}, 32'd1);
        chk("t4_rd_block_ok", {31'd0, bus.data_addr_ok}, 32'd0);
        tick();
        bus.bvalid = 0;
        #1;
        chk("t4_rd_accept", {31'd0, bus.data_addr_ok}, 32'd1);
        tick();
        bus.data_req = 0; bus.arready = 1;
        #1;
        chk("t4_araddr", bus.araddr, 32'h200);
        chk("t4_arid", {28'd0, bus.arid}, 32'd1);
        tick();
        bus.arready = 0; bus.rvalid = 1; bus.rid = 1; bus.rdata = mem200;
        #1;
        chk("t4_rd_ok", {31'd0, bus.data_data_ok}, 32'd1);
        chk("t4_rd_data", bus.data_rdata, 32'hcafe_beef);
        tick();
        bus.rvalid = 0;

        // Inst read and data write completing in the same cycle
        bus.inst_req = 1; bus.inst_addr = 32'h1c00_0008; bus.inst_size = 2;
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h300;
        bus.data_wstrb = 4'hf; bus.data_wdata = 32'h1234_5678;
        #1;
        chk("t5_both_addr_ok", {30'd0, bus.inst_addr_ok, bus.data_addr_ok}, 32'd3);
        tick();
        bus.inst_req = 0; bus.data_req = 0;
        bus.arready = 1; bus.awready = 1; bus.wready = 1;
        #1;
        chk("t5_valids", {29'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 32'd7);
        chk("t5_awaddr_wdata", bus.awaddr ^ bus.wdata, 32'h300 ^ 32'h1234_5678);
        tick();
        bus.arready = 0; bus.awready = 0; bus.wready = 0;
        bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h0bad_f00d; bus.bvalid = 1;
        #1;
        chk("t5_both_data_ok", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd3);
        chk("t5_inst_rdata", bus.inst_rdata, 32'h0bad_f00d);
        tick();
        bus.rvalid = 0; bus.bvalid = 0;
        #1;
        chk("t5_idle", {28'd0, bus.rready, bus.bready, bus.inst_data_ok, bus.data_data_ok}, 32'd0);

        // Reset while waiting for read data
        bus.inst_req = 1; bus.inst_addr = 32'h1c00_000c;
        tick();
        bus.inst_req = 0; bus.arready = 1;
        tick();
        bus.arready = 0;
        #1;
        chk("t6_in_rr", {31'd0, bus.rready}, 32'd1);
        reset = 1;
        #1;
        chk("t6_no_data_ok", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd0);
        tick();
        chk("t6_after_rst", {30'd0, bus.arvalid, bus.rready}, 32'd0);
        reset = 0;
        tick();
        bus.inst_req = 1; bus.inst_addr = 32'h1c00_0010;
        #1;
        chk("t6_new_accept", {31'd0, bus.inst_addr_ok}, 32'd1);
        tick();
        bus.inst_req = 0; bus.arready = 1;
        #1;
        chk("t6_new_araddr", bus.araddr, 32'h1c00_0010);
        tick();
        bus.arready = 0; bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h0000_0013;
        #1;
        chk("t6_new_done", {31'd0, bus.inst_data_ok}, 32'd1);
        chk("t6_new_rdata", bus.inst_rdata, 32'h0000_0013);
        tick();
        bus.rvalid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Responder side of the CPU's SRAM-like instruction and data ports: accepts requests from the CPU core and converts them into single-beat AXI3 transactions on one shared AXI master port. Sits between the CPU top and the SoC AXI interconnect. Keeps at most one outstanding read, one outstanding write, and one outstanding transaction per data port, so responses are never reordered.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req / inst_wr  in  1 / 1  instruction request; wr is ignored and treated as a read
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb / inst_wdata  in  4 / 32  ignored
- inst_addr  in  32  byte address
- inst_addr_ok / inst_data_ok  out  1 / 1  request accepted / read data valid (1-cycle pulse)
- inst_rdata  out  32  read data
- data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  in  1/1/2/4/32/32  data request
- data_addr_ok / data_data_ok  out  1 / 1  accept / completion pulse (read or write)
- data_rdata  out  32  read data
- arid  out  4  0 = inst, 1 = data
- araddr / arsize / arvalid  out  32/3/1  read address; arready  in  1
- rid / rdata / rresp / rlast / rvalid  in  4/32/2/1/1  read data; rready  out  1
- awaddr / awsize / awvalid  out  32/3/1  write address; awready  in  1
- wdata / wstrb / wvalid  out  32/4/1  write data; wready  in  1
- bid / bresp / bvalid  in  4/2/1  write response; bready  out  1
- Constant outputs: arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0, awid=1, awlen=0, awburst=2'b01, awlock=0, awcache=0, awprot=0, wid=1, wlast=1.

## Operation
- Read FSM states:
  - R_IDLE -> R_AR on an accepted read.
  - R_AR: arvalid=1; -> R_R on arvalid&arready.
  - R_R: rready=1; -> R_IDLE on rvalid.
- Write FSM states:
  - W_IDLE -> W_AW on an accepted write.
  - W_AW: awvalid and wvalid both raised. Each drops independently after its own handshake. -> W_B once both handshakes are done; a same-cycle handshake on both is legal.
  - W_B: bready=1; -> W_IDLE on bvalid.
- data_busy flag: set when a data request is accepted, cleared on data_data_ok.
- Acceptance rules (addr_ok is combinational):
  - data read: data_req & !data_wr & R_IDLE & !data_busy & W_IDLE.
  - data write: data_req & data_wr & W_IDLE & !data_busy.
  - inst read: inst_req & R_IDLE & !(data read accepted this cycle).
  - A data read has priority over an inst read. A data read is never issued while a write is outstanding, so no RAW hazard can occur.
- On req&addr_ok, register addr, size, wstrb, wdata and the source ID. AXI fields come only from these registers. arsize/awsize = {1'b0, size}.
- Responses:
  - inst_data_ok = rvalid & rready & rid==0.
  - data_data_ok = (rvalid & rready & rid==1) | (bvalid & bready).
  - inst_rdata = data_rdata = rdata (pass-through).
  - rresp and bresp are ignored.
- Simultaneous events: an inst read completing and a data write completing in the same cycle is legal and goes to separate ports. Two completions on the data port in one cycle are impossible by construction.

## Timing
- In reset: both FSMs idle; all valid/ready outputs 0; all addr_ok and data_ok 0; data_busy 0.
- Reset asserted mid-transaction: both FSMs return to idle and outstanding state is dropped with no data_ok. The interconnect is reset together with the bridge.
- Read latency: cycle 0 req&addr_ok; cycle 1 arvalid. With arready=1 at cycle 1 and rvalid at cycle 2, data_ok and rdata appear in cycle 2.
- Write latency: cycle 0 accept; cycle 1 awvalid and wvalid. With ready and bvalid at cycle 2, data_data_ok appears in cycle 2.
- arvalid, awvalid and wvalid never drop before their handshake, and their payloads stay stable until then.
- addr_ok may be 1 only in a cycle where req=1.

## Test plan
- Inst read, addr 0x1c000000, size 2; slave with arready=1 and 1-cycle rvalid, rdata=0x02800000, rid=0 -> arid=0, araddr=0x1c000000, arsize=2; inst_data_ok pulses once with inst_rdata=0x02800000.
- inst_req and data read (addr 0x100) both asserted in one cycle -> data_addr_ok=1, inst_addr_ok=0, arid=1 first. The inst request is accepted in the cycle after rvalid.
- Data write, addr 0x200, wstrb 4'b0011, wdata 0xdeadbeef; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles; data_data_ok pulses on bvalid.
- Data write in flight, then data read to 0x200 -> data_addr_ok stays 0 until the cycle after data_data_ok for the write. The read then returns the written value from a memory model.
- Inst read outstanding plus data write; rvalid (rid=0) and bvalid land in the same cycle -> inst_data_ok and data_data_ok both pulse in that cycle.
- Assert reset while in R_R -> arvalid=rready=0 next cycle, no data_ok. After reset release, a new inst read completes normally.
